hdb3_vb_sched: RTL and testbench

- Substitution scheduler for the HDB3 transmit path.
- Accepts a strobed NRZ bit stream and detects runs of four zeros.
- Replaces each run with 000V or B00V, chosen by mark parity since the last V.
- Emits 2-bit symbol codes to the downstream polarity converter: 00 zero, 01 mark, 11 V, 10 B.
- Holds a 4-symbol look-back buffer so a B can be inserted retroactively at the start of a zero run.

---
 rtl/hdb3_vb_sched.sv | 123 ++++++++++++
 tb/tb_hdb3_vb_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdb3_vb_sched.sv
// HDB3 substitution scheduler.
// Takes a strobed NRZ bit stream and replaces every run of four zeros with
// 000V or B00V. The choice depends on the mark parity since the last V.
// A 4-symbol look-back buffer holds recent symbols so that a B can still be
// written into the first zero of a run after the run has been recognised.
// Each symbol leaves the block exactly four strobes after its bit arrived.
module hdb3_vb_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             hdb3_en,
  output logic [1:0]       code_out,
  output logic             code_valid,
  output logic [CNT_W-1:0] v_count
);

  // Symbol codes sent to the polarity converter.
  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_MARK = 2'b01,
    SYM_B    = 2'b10,
    SYM_V    = 2'b11
  } sym_t;

  localparam logic [2:0]       FILL_FULL = 3'd4;
  localparam logic [1:0]       ZCNT_MAX  = 2'd3;
  localparam logic [CNT_W-1:0] VCNT_MAX  = {CNT_W{1'b1}};

  // sr_q[0] holds the newest symbol and sr_q[3] the oldest, which is sent next.
  sym_t             sr_q [4];
  sym_t             sr_d [4];
  logic [1:0]       zcnt_q, zcnt_d;       // zeros seen since the last mark or V, capped at 3
  logic             parity_q, parity_d;   // marks since the last V, modulo 2
  logic [2:0]       fill_q, fill_d;       // number of valid buffer entries, capped at 4
  logic [CNT_W-1:0] v_count_q, v_count_d;
  sym_t             code_out_q, code_out_d;
  logic             code_valid_q, code_valid_d;

  logic             subst;

  // Next-state logic: shift in one symbol per strobe and apply substitution.
  // NOTE: every signal gets a default at the top of the block, so no path can
  // leave one unassigned and infer a latch. Blocking '=' is correct here because
  // this block is combinational.
  always_comb begin
    sr_d         = sr_q;
    zcnt_d       = zcnt_q;
    parity_d     = parity_q;
    fill_d       = fill_q;
    v_count_d    = v_count_q;
    code_out_d   = code_out_q;
    code_valid_d = 1'b0;
    subst        = 1'b0;

    if (din_valid) begin
      // The oldest symbol is sent before the shift. It only counts as valid
      // after the buffer has filled once.
      code_out_d   = sr_q[3];
      code_valid_d = (fill_q == FILL_FULL);

      sr_d[3] = sr_q[2];
      sr_d[2] = sr_q[1];
      sr_d[1] = sr_q[0];
      sr_d[0] = din ? SYM_MARK : SYM_ZERO;
      fill_d  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 3'd1;

      subst = hdb3_en && !din && (zcnt_q == ZCNT_MAX);

      if (subst) begin
        sr_d[0] = SYM_V;
        // When the parity is even, the first zero of the run has just moved
        // into sr[3]. That zero becomes the B.
        if (!parity_q) begin
          sr_d[3] = SYM_B;
        end
        zcnt_d    = 2'd0;
        parity_d  = 1'b0;
        v_count_d = (v_count_q == VCNT_MAX) ? VCNT_MAX : v_count_q + 1'b1;
      end else if (din) begin
        zcnt_d   = 2'd0;
        parity_d = ~parity_q;
      end else begin
        // The cap at 3 only matters while substitution is disabled.
        zcnt_d = (zcnt_q == ZCNT_MAX) ? ZCNT_MAX : zcnt_q + 2'd1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  // NOTE: the look-back buffer is reset on purpose. A reset in the middle of
  // the stream must discard every buffered symbol, so that no partial zero run
  // can combine with zeros that arrive after the reset. Sequential state uses
  // non-blocking '<=' only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        sr_q[i] <= SYM_ZERO;
      end
      zcnt_q       <= 2'd0;
      parity_q     <= 1'b0;
      fill_q       <= 3'd0;
      v_count_q    <= '0;
      code_out_q   <= SYM_ZERO;
      code_valid_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      zcnt_q       <= zcnt_d;
      parity_q     <= parity_d;
      fill_q       <= fill_d;
      v_count_q    <= v_count_d;
      code_out_q   <= code_out_d;
      code_valid_q <= code_valid_d;
    end
  end

  assign code_out   = code_out_q;
  assign code_valid = code_valid_q;
  assign v_count    = v_count_q;

endmodule

// File: tb/tb_hdb3_vb_sched.sv
// Self-checking bench for hdb3_vb_sched.
// The reference model keeps the whole emitted symbol list for the current
// stream and edits the entry three bits back when a B is due. Fixed vectors
// are written directly as symbol strings.
module tb_hdb3_vb_sched;

  localparam int CW   = 3;
  localparam int VMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          din_valid;
  logic          din;
  logic          hdb3_en;
  logic [1:0]    code_out;
  logic          code_valid;
  logic [CW-1:0] v_count;

  hdb3_vb_sched #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .hdb3_en    (hdb3_en),
    .code_out   (code_out),
    .code_valid (code_valid),
    .v_count    (v_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  logic [1:0] mq[$];    // symbol emitted for every input bit since reset
  int         m_run;    // zeros since the last mark or V, capped at 3
  int         m_par;    // marks since the last V, modulo 2
  int         m_v;      // saturating substitution count
  logic [1:0] m_code;   // last code_out value
  logic [1:0] cap[$];   // symbols the DUT has marked valid

  typedef struct {
    int               nb;
    logic [31:0]      bits;
    logic [31:0]      en;
    logic [31:0][1:0] exp;
    int               ne;
    int               v;
    bit               gaps;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_run  = 0;
    m_par  = 0;
    m_v    = 0;
    m_code = 2'b00;
  endtask

  // Hold reset for some cycles while strobes keep arriving.
  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst_n     = 1'b0;
      din_valid = 1'b1;
      din       = 1'($urandom);
      hdb3_en   = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      check("rst_code_out", int'(code_out), 0);
      check("rst_code_valid", int'(code_valid), 0);
      check("rst_v_count", int'(v_count), 0);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      din       = 1'($urandom);
      hdb3_en   = 1'($urandom);
      @(posedge clk);
      #1;
      check("idle_valid", int'(code_valid), 0);
      check("idle_code_hold", int'(code_out), int'(m_code));
      check("idle_v_count", int'(v_count), m_v);
    end
  endtask

  task automatic strobe(input bit d, input bit en);
    int         n;
    bit         exp_valid;
    logic [1:0] exp_code;
    @(negedge clk);
    din_valid = 1'b1;
    din       = d;
    hdb3_en   = en;
    @(posedge clk);
    #1;
    n         = mq.size();
    exp_valid = (n >= 4);
    exp_code  = exp_valid ? mq[n-4] : 2'b00;
    if (en && !d && m_run >= 3) begin
      mq.push_back(2'b11);
      if (m_par == 0) mq[n-3] = 2'b10;
      m_run = 0;
      m_par = 0;
      if (m_v < VMAX) m_v++;
    end else if (d) begin
      mq.push_back(2'b01);
      m_run = 0;
      m_par ^= 1;
    end else begin
      mq.push_back(2'b00);
      if (m_run < 3) m_run++;
    end
    m_code = exp_code;
    check("strobe_valid", int'(code_valid), int'(exp_valid));
    check("strobe_code", int'(code_out), int'(exp_code));
    check("strobe_v_count", int'(v_count), m_v);
    if (code_valid) cap.push_back(code_out);
  endtask

  // Build a vector from strings. b is the input bits ('0'/'1'). e is the
  // per-bit hdb3_en ('0'/'1'), and an empty e means all enabled. x is the
  // expected symbols ('0','1','B','V').
  function automatic vec_t mk(input string b, input string e, input string x,
                              input int v, input bit g);
    vec_t r;
    r.nb   = b.len();
    r.ne   = x.len();
    r.v    = v;
    r.gaps = g;
    r.bits = '0;
    r.en   = '1;
    r.exp  = '0;
    for (int i = 0; i < b.len(); i++) r.bits[i] = (b[i] == "1");
    for (int i = 0; i < e.len(); i++) r.en[i] = (e[i] == "1");
    for (int i = 0; i < x.len(); i++) begin
      case (x[i])
        "1":     r.exp[i] = 2'b01;
        "V":     r.exp[i] = 2'b11;
        "B":     r.exp[i] = 2'b10;
        default: r.exp[i] = 2'b00;
      endcase
    end
    return r;
  endfunction

  task automatic pad();
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    hdb3_en   = 1'b1;
    model_reset();

    tbl[0] = mk("10000", "", "1000V", 1, 1'b0);
    tbl[1] = mk("00000000", "", "B00VB00V", 2, 1'b0);
    tbl[2] = mk("110000", "", "11B00V", 1, 1'b1);
    tbl[3] = mk("00000000", "00000000", "00000000", 0, 1'b0);
    tbl[4] = mk("000000000", "000000001", "00000B00V", 1, 1'b0);
    tbl[5] = mk("100000000", "", "1000VB00V", 2, 1'b1);
    tbl[6] = mk("00000000000000000000000000000000", "",
                "B00VB00VB00VB00VB00VB00VB00VB00V", VMAX, 1'b0);

    // Reset held over strobes, then the first four strobes stay invalid.
    do_reset(2);
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1);
    check("fill_no_valid", cap.size(), 0);

    // Table-driven vectors, each starting from reset and flushed by a pad.
    foreach (tbl[t]) begin
      do_reset(1);
      cap.delete();
      for (int i = 0; i < tbl[t].nb; i++) begin
        strobe(tbl[t].bits[i], tbl[t].en[i]);
        if (tbl[t].gaps) idle($urandom_range(0, 3));
      end
      pad();
      check($sformatf("tbl%0d_len", t), cap.size(), tbl[t].ne);
      for (int j = 0; j < tbl[t].ne; j++)
        check($sformatf("tbl%0d_code%0d", t, j),
              (j < cap.size()) ? int'(cap[j]) : -1, int'(tbl[t].exp[j]));
      check($sformatf("tbl%0d_v_count", t), int'(v_count), tbl[t].v);
    end

    // A reset in the middle of a zero run discards the partial run.
    do_reset(1);
    cap.delete();
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1);
    do_reset(1);
    strobe(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b1);
    pad();
    check("midrst_len", cap.size(), 5);
    check("midrst_code0", (cap.size() > 0) ? int'(cap[0]) : -1, 0);
    check("midrst_code1", (cap.size() > 1) ? int'(cap[1]) : -1, 1);
    check("midrst_v_count", int'(v_count), 0);

    // Randomised stream compared against the model on every cycle.
    do_reset(1);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      else strobe(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) != 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
